// File: rtl/line_bank_wren_ctrl.sv
// Line-buffer bank write-enable controller.
// Steers incoming pixels into one of NUM_BANKS line RAMs and tracks how many
// complete lines are waiting for the consumer. A line whose start finds every
// bank occupied is discarded whole and counted.
module line_bank_wren_ctrl #(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned LINE_LEN  = 1280,
    localparam int unsigned ADDR_W   = $clog2(LINE_LEN),
    localparam int unsigned BANK_W   = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 clk,
    input  logic                 aclr_n,
    input  logic                 sof,
    input  logic                 data_valid,
    input  logic                 rd_release,
    output logic [NUM_BANKS-1:0] wren,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [BANK_W-1:0]    wr_bank,
    output logic [BANK_W-1:0]    rd_bank,
    output logic [BANK_W:0]      lines_avail,
    output logic                 line_done,
    output logic                 drop_active,
    output logic [15:0]          drop_count,
    output logic                 overflow
);

    localparam logic [ADDR_W-1:0] LastPix  = ADDR_W'(LINE_LEN - 1);
    localparam logic [BANK_W-1:0] LastBank = BANK_W'(NUM_BANKS - 1);
    localparam logic [BANK_W:0]   AllFull  = (BANK_W + 1)'(NUM_BANKS);
    localparam logic [BANK_W:0]   AvailOne = (BANK_W + 1)'(1);

    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic                 drop_line_q, drop_line_d;
    logic [NUM_BANKS-1:0] wren_q, wren_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [BANK_W-1:0]    wr_bank_q, wr_bank_d;
    logic [BANK_W-1:0]    rd_bank_q, rd_bank_d;
    logic [BANK_W:0]      avail_q, avail_d;
    logic                 line_done_q, line_done_d;
    logic                 drop_active_q, drop_active_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;
    logic                 ovf_q, ovf_d;

    logic [ADDR_W-1:0] cnt_eff;
    logic              drop_eff;
    logic              dropping_now;
    logic              last_pix;
    logic              store_done;
    logic              drop_done;
    logic              rel_ok;

    function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
        return (b == LastBank) ? '0 : b + BANK_W'(1);
    endfunction

    // Next-state: pixel counter, drop decision, bank rotation and line accounting.
    always_comb begin
        // sof restarts the line; a same-cycle pixel becomes pixel 0
        cnt_eff      = sof ? '0 : cnt_q;
        drop_eff     = sof ? 1'b0 : drop_line_q;
        dropping_now = (cnt_eff == '0) ? (avail_q == AllFull) : drop_eff;
        last_pix     = data_valid && (cnt_eff == LastPix);
        store_done   = last_pix && !dropping_now;
        drop_done    = last_pix && dropping_now;
        rel_ok       = rd_release && (avail_q != '0);

        cnt_d         = cnt_eff;
        drop_line_d   = drop_eff;
        wren_d        = '0;
        wr_addr_d     = wr_addr_q;
        drop_active_d = drop_eff;
        if (data_valid) begin
            cnt_d         = last_pix ? '0 : cnt_eff + ADDR_W'(1);
            drop_line_d   = last_pix ? 1'b0 : dropping_now;
            wren_d        = dropping_now ? '0 : (NUM_BANKS'(1) << wr_bank_q);
            wr_addr_d     = cnt_eff;
            // stays high through the final discarded pixel, clears afterwards
            drop_active_d = dropping_now;
        end

        line_done_d = store_done;
        wr_bank_d   = store_done ? bank_inc(wr_bank_q) : wr_bank_q;
        rd_bank_d   = rel_ok ? bank_inc(rd_bank_q) : rd_bank_q;

        avail_d = avail_q;
        if (store_done && !rel_ok) begin
            avail_d = avail_q + AvailOne;
        end else if (!store_done && rel_ok) begin
            avail_d = avail_q - AvailOne;
        end

        drop_cnt_d = drop_cnt_q;
        if (drop_done && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        ovf_d = ovf_q | drop_done;
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            cnt_q         <= '0;
            drop_line_q   <= 1'b0;
            wren_q        <= '0;
            wr_addr_q     <= '0;
            wr_bank_q     <= '0;
            rd_bank_q     <= '0;
            avail_q       <= '0;
            line_done_q   <= 1'b0;
            drop_active_q <= 1'b0;
            drop_cnt_q    <= '0;
            ovf_q         <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            drop_line_q   <= drop_line_d;
            wren_q        <= wren_d;
            wr_addr_q     <= wr_addr_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            avail_q       <= avail_d;
            line_done_q   <= line_done_d;
            drop_active_q <= drop_active_d;
            drop_cnt_q    <= drop_cnt_d;
            ovf_q         <= ovf_d;
        end
    end

    assign wren        = wren_q;
    assign wr_addr     = wr_addr_q;
    assign wr_bank     = wr_bank_q;
    assign rd_bank     = rd_bank_q;
    assign lines_avail = avail_q;
    assign line_done   = line_done_q;
    assign drop_active = drop_active_q;
    assign drop_count  = drop_cnt_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_line_bank_wren_ctrl.sv
// Scoreboard bench for line_bank_wren_ctrl with NUM_BANKS=2, LINE_LEN=8.
module tb_line_bank_wren_ctrl;

    logic       clk;
    logic       aclr_n;
    logic       sof;
    logic       data_valid;
    logic       rd_release;
    logic [1:0] wren;
    logic [2:0] wr_addr;
    logic       wr_bank;
    logic       rd_bank;
    logic [1:0] lines_avail;
    logic       line_done;
    logic       drop_active;
    logic [15:0] drop_count;
    logic       overflow;

    typedef struct packed {
        logic [1:0] wren;
        logic [2:0] addr;
        logic       done;
        logic       drop;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    line_bank_wren_ctrl #(
        .NUM_BANKS(2),
        .LINE_LEN (8)
    ) dut (
        .clk        (clk),
        .aclr_n     (aclr_n),
        .sof        (sof),
        .data_valid (data_valid),
        .rd_release (rd_release),
        .wren       (wren),
        .wr_addr    (wr_addr),
        .wr_bank    (wr_bank),
        .rd_bank    (rd_bank),
        .lines_avail(lines_avail),
        .line_done  (line_done),
        .drop_active(drop_active),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every presented pixel slot is matched against the oldest expectation.
    always @(negedge clk) begin
        if (aclr_n === 1'b1 && (wren != 2'b00 || line_done || drop_active)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: wren=%b addr=%0d done=%b drop=%b, none expected",
                         wren, wr_addr, line_done, drop_active);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (wren !== e.wren || line_done !== e.done || drop_active !== e.drop ||
                    (e.wren != 2'b00 && wr_addr !== e.addr)) begin
                    failures++;
                    $display("FAIL pixel_slot: got wren=%b addr=%0d done=%b drop=%b expected wren=%b addr=%0d done=%b drop=%b",
                             wren, wr_addr, line_done, drop_active, e.wren, e.addr, e.done, e.drop);
                end
            end
        end
    end

    // One cycle of stimulus; a valid pixel pushes its hand-computed response.
    task automatic px(input logic v, input logic s, input logic rel,
                      input logic [1:0] ew, input int ea, input logic ed, input logic edr);
        exp_t e;
        data_valid = v;
        sof        = s;
        rd_release = rel;
        if (v) begin
            e.wren = ew;
            e.addr = 3'(ea);
            e.done = ed;
            e.drop = edr;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        sof        = 1'b0;
        rd_release = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wren"}, 16'(wren), 16'h0);
        chk({tag, "_wr_addr"}, 16'(wr_addr), 16'h0);
        chk({tag, "_wr_bank"}, 16'(wr_bank), 16'h0);
        chk({tag, "_rd_bank"}, 16'(rd_bank), 16'h0);
        chk({tag, "_lines_avail"}, 16'(lines_avail), 16'h0);
        chk({tag, "_line_done"}, 16'(line_done), 16'h0);
        chk({tag, "_drop_active"}, 16'(drop_active), 16'h0);
        chk({tag, "_drop_count"}, drop_count, 16'h0);
        chk({tag, "_overflow"}, 16'(overflow), 16'h0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        aclr_n     = 1'b0;
        sof        = 1'b0;
        data_valid = 1'b0;
        rd_release = 1'b0;
        #2;
        chk_zero("reset_pre_clk");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        aclr_n = 1'b1;
        @(posedge clk);
        #1;

        // Line 1: contiguous pixels into bank 0
        for (int i = 0; i < 8; i++) px(1'b1, 1'b0, 1'b0, 2'b01, i, i == 7, 1'b0);
        chk("l1_wr_bank", 16'(wr_bank), 16'd1);
        chk("l1_lines_avail", 16'(lines_avail), 16'd1);

        // Line 2: alternating valid/gap into bank 1
        for (int i = 0; i < 8; i++) begin
            px(1'b1, 1'b0, 1'b0, 2'b10, i, i == 7, 1'b0);
            px(1'b0, 1'b0, 1'b0, 2'b00, 0, 1'b0, 1'b0);
        end
        chk("l2_wr_bank", 16'(wr_bank), 16'd0);
        chk("l2_lines_avail", 16'(lines_avail), 16'd2);

        // Line 3: both banks full, whole line discarded
        for (int i = 0; i < 8; i++) px(1'b1, 1'b0, 1'b0, 2'b00, i, 1'b0, 1'b1);
        chk("drop_count", drop_count, 16'd1);
        chk("drop_overflow", 16'(overflow), 16'd1);
        chk("drop_wr_bank", 16'(wr_bank), 16'd0);
        chk("drop_lines_avail", 16'(lines_avail), 16'd2);
        px(1'b0, 1'b0, 1'b0, 2'b00, 0, 1'b0, 1'b0);
        chk("drop_active_cleared", 16'(drop_active), 16'd0);

        // Single release
        px(1'b0, 1'b0, 1'b1, 2'b00, 0, 1'b0, 1'b0);
        chk("rel_lines_avail", 16'(lines_avail), 16'd1);
        chk("rel_rd_bank", 16'(rd_bank), 16'd1);

        // Release coinciding with completion of a bank-0 line
        for (int i = 0; i < 8; i++) px(1'b1, 1'b0, i == 7, 2'b01, i, i == 7, 1'b0);
        chk("coinc_lines_avail", 16'(lines_avail), 16'd1);
        chk("coinc_rd_bank", 16'(rd_bank), 16'd0);
        chk("coinc_wr_bank", 16'(wr_bank), 16'd1);

        // Drain, then release on empty is ignored
        px(1'b0, 1'b0, 1'b1, 2'b00, 0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 1'b1, 2'b00, 0, 1'b0, 1'b0);
        chk("empty_lines_avail", 16'(lines_avail), 16'd0);
        chk("empty_rd_bank", 16'(rd_bank), 16'd1);
        chk("overflow_sticky", 16'(overflow), 16'd1);

        // sof alone after pixel 2, then sof with a pixel after pixel 5
        for (int i = 0; i < 3; i++) px(1'b1, 1'b0, 1'b0, 2'b10, i, 1'b0, 1'b0);
        px(1'b0, 1'b1, 1'b0, 2'b00, 0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) px(1'b1, 1'b0, 1'b0, 2'b10, i, 1'b0, 1'b0);
        px(1'b1, 1'b1, 1'b0, 2'b10, 0, 1'b0, 1'b0);
        chk("sof_lines_avail", 16'(lines_avail), 16'd0);
        chk("sof_wr_bank", 16'(wr_bank), 16'd1);
        for (int i = 1; i < 8; i++) px(1'b1, 1'b0, 1'b0, 2'b10, i, i == 7, 1'b0);
        chk("sof_done_lines_avail", 16'(lines_avail), 16'd1);
        chk("sof_done_wr_bank", 16'(wr_bank), 16'd0);

        // Asynchronous reset mid-line at addr 4
        for (int i = 0; i < 5; i++) px(1'b1, 1'b0, 1'b0, 2'b01, i, 1'b0, 1'b0);
        chk("pre_reset_addr", 16'(wr_addr), 16'd4);
        @(negedge clk);
        #1;
        aclr_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(posedge clk);
        #1;
        aclr_n = 1'b1;
        for (int i = 0; i < 8; i++) px(1'b1, 1'b0, 1'b0, 2'b01, i, i == 7, 1'b0);
        chk("restart_wr_bank", 16'(wr_bank), 16'd1);
        chk("restart_lines_avail", 16'(lines_avail), 16'd1);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
